// File: rtl/reg7_tx_pkg.sv
// Shared types and constants for the 7-bit register serial transmitter.
package reg7_tx_pkg;

  localparam int unsigned WORD_W   = 7;
  localparam int unsigned BITCNT_W = 3;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Frame length in clocks: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned cpb, input bit par_en);
    return (par_en ? WORD_W + 3 : WORD_W + 2) * cpb;
  endfunction

endpackage

// File: rtl/reg7_serial_tx_if.sv
// Load/serial-line bundle between a register source and the serial transmitter.
interface reg7_serial_tx_if;
  import reg7_tx_pkg::*;

  logic              en;
  logic [WORD_W-1:0] d;
  logic              tx;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (output en, d, input tx, ready, busy, done);
  modport slave  (input en, d, output tx, ready, busy, done);

endinterface

// File: rtl/reg7_serial_tx_bit_timer.sv
// Per-bit cycle counter; bit_tick is high on the last cycle of each serial bit.
module bit_timer
  import reg7_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick,
  output logic tick_next_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next_c;

  always_comb begin
    cnt_next_c = cnt + CNT_W'(1);
    if (clr || (cnt == LAST)) cnt_next_c = '0;
  end

  // Lookahead lets the tick itself be a registered output, even at one clock per bit.
  assign tick_next_c = (cnt_next_c == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= cnt_next_c;
      bit_tick <= tick_next_c;
    end
  end

endmodule

// File: rtl/reg7_serial_tx.sv
// Serialises a 7-bit register word as start, LSB-first data, optional even parity, stop.
module reg7_serial_tx
  import reg7_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  reg7_serial_tx_if.slave bus
);

  tx_state_t           state;
  logic [WORD_W-1:0]   shift;
  logic [BITCNT_W-1:0] bitcnt;
  logic                par;
  logic                tx_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                bit_tick;
  logic                tick_next_c;
  logic                clr_c;

  // Timer restarts on entry to every state; it is held at zero while idle.
  assign clr_c = (state == IDLE) || bit_tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr_c),
    .bit_tick    (bit_tick),
    .tick_next_c (tick_next_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= '0;
      bitcnt  <= '0;
      par     <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_q && bus.en) begin
            shift   <= bus.d;
            par     <= ^bus.d;
            state   <= START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state  <= DATA;
            tx_q   <= shift[0];
            bitcnt <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bitcnt == BITCNT_W'(WORD_W - 1)) begin
              if (PARITY_EN) begin
                state <= PARITY;
                tx_q  <= par;
              end else begin
                state  <= STOP;
                tx_q   <= 1'b1;
                done_q <= tick_next_c;
              end
            end else begin
              shift  <= shift >> 1;
              tx_q   <= shift[1];
              bitcnt <= bitcnt + BITCNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state  <= STOP;
            tx_q   <= 1'b1;
            done_q <= tick_next_c;
          end
        end
        STOP: begin
          // done is raised one edge early so it lands on the final stop cycle.
          if (bit_tick) begin
            state   <= IDLE;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            done_q <= tick_next_c;
          end
        end
        default: begin
          state   <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_reg7_serial_tx.sv
// Scoreboard bench for reg7_serial_tx: two instances (4 clk/bit with parity, 1 clk/bit without).
module tb_reg7_serial_tx;

  localparam int unsigned CPB0 = 4;
  localparam bit          PAR0 = 1'b1;
  localparam int unsigned CPB1 = 1;
  localparam bit          PAR1 = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn0;
  logic rstn1;

  reg7_serial_tx_if b0 ();
  reg7_serial_tx_if b1 ();

  reg7_serial_tx #(.CLKS_PER_BIT(CPB0), .PARITY_EN(PAR0)) dut0 (
    .clk(clk), .reset(rstn0), .bus(b0)
  );
  reg7_serial_tx #(.CLKS_PER_BIT(CPB1), .PARITY_EN(PAR1)) dut1 (
    .clk(clk), .reset(rstn1), .bus(b1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] q0[$];
  logic [6:0] q1[$];

  int unsigned rem[2];
  bit          mready[2];
  bit          infr[2];
  int unsigned ocnt[2];
  logic [63:0] obs[2];

  function automatic int unsigned cpb_of(input int i);
    return (i == 0) ? CPB0 : CPB1;
  endfunction

  function automatic bit par_of(input int i);
    return (i == 0) ? PAR0 : PAR1;
  endfunction

  function automatic int unsigned flen(input int i);
    return (par_of(i) ? 10 : 9) * cpb_of(i);
  endfunction

  // Expected tx waveform, one bit per clock, cycle 0 in bit 0.
  function automatic logic [63:0] exp_frame(input logic [6:0] w, input int i);
    logic [9:0]  b;
    logic [63:0] e;
    int unsigned nb;
    int unsigned ones;
    nb   = par_of(i) ? 10 : 9;
    b    = '0;
    e    = '0;
    ones = 0;
    for (int k = 0; k < 7; k++) begin
      b[k+1] = w[k];
      if (w[k]) ones++;
    end
    if (par_of(i)) b[8] = (ones % 2 == 1);
    b[nb-1] = 1'b1;
    for (int c = 0; c < int'(nb * cpb_of(i)); c++) e[c] = b[c / cpb_of(i)];
    return e;
  endfunction

  task automatic check_bit(input string name, input int inst, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b", name, inst, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input int inst, input logic [63:0] act,
                           input logic [63:0] exp, input logic [6:0] w);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d word=%h t=%0t got=%h want=%h", name, inst, w, $time, act, exp);
    end
  endtask

  // Reference model: ready/busy/done timing from frame length alone; accepted words go to the scoreboard.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic       r;
      logic       e;
      logic [6:0] dd;
      r  = (i == 0) ? rstn0 : rstn1;
      e  = (i == 0) ? b0.en : b1.en;
      dd = (i == 0) ? b0.d  : b1.d;
      if (!r) begin
        rem[i]    <= 0;
        mready[i] <= 1'b0;
        if (i == 0) q0.delete(); else q1.delete();
      end else if (mready[i] && e) begin
        mready[i] <= 1'b0;
        rem[i]    <= flen(i);
        if (i == 0) q0.push_back(dd); else q1.push_back(dd);
      end else if (rem[i] > 1) begin
        rem[i] <= rem[i] - 1;
      end else begin
        rem[i]    <= 0;
        mready[i] <= 1'b1;
      end
    end
  end

  // Monitor: per-cycle handshake checks, and frame capture compared against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic       r, tx, rdy, bsy, dn;
      logic [6:0] w;
      r   = (i == 0) ? rstn0   : rstn1;
      tx  = (i == 0) ? b0.tx   : b1.tx;
      rdy = (i == 0) ? b0.ready : b1.ready;
      bsy = (i == 0) ? b0.busy : b1.busy;
      dn  = (i == 0) ? b0.done : b1.done;
      check_bit("ready", i, rdy, mready[i]);
      check_bit("busy", i, bsy, rem[i] != 0);
      check_bit("done", i, dn, rem[i] == 1);
      if (rem[i] == 0) check_bit("idle_tx", i, tx, 1'b1);
      if (!r) begin
        infr[i] = 1'b0;
      end else begin
        if (!infr[i] && tx == 1'b0) begin
          infr[i] = 1'b1;
          ocnt[i] = 0;
          obs[i]  = '0;
        end
        if (infr[i]) begin
          obs[i][ocnt[i]] = tx;
          ocnt[i]++;
          if (ocnt[i] == flen(i)) begin
            infr[i] = 1'b0;
            if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_unexpected dut%0d t=%0t got=frame want=none", i, $time);
            end else begin
              w = (i == 0) ? q0.pop_front() : q1.pop_front();
              check_vec("frame", i, obs[i], exp_frame(w, i), w);
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0;
    b0.en = 1'b0; b0.d = '0;
    b1.en = 1'b0; b1.d = '0;
    step(2);
    rstn0 = 1'b1; rstn1 = 1'b1;
    step(2);

    // Single frame, lowest bit set.
    b0.d = 7'h01; b0.en = 1'b1; step(1); b0.en = 1'b0; step(45);

    // 0x55, then d and en disturbed mid-frame.
    b0.d = 7'h55; b0.en = 1'b1; step(1); b0.en = 1'b0; step(10);
    b0.d = 7'h00; b0.en = 1'b1; step(5); b0.en = 1'b0; step(30);

    // en held high: back-to-back frames.
    b0.d = 7'h7F; b0.en = 1'b1; step(50); b0.en = 1'b0; step(40);

    // Reset during data bit 3, then a fresh word.
    b0.d = 7'h33; b0.en = 1'b1; step(1); b0.en = 1'b0; step(17);
    rstn0 = 1'b0; step(2); rstn0 = 1'b1; step(2);
    b0.d = 7'h2A; b0.en = 1'b1; step(1); b0.en = 1'b0; step(45);

    repeat (600) begin
      b0.en = ($urandom % 5 == 0);
      b0.d  = 7'($urandom);
      step(1);
    end
    b0.en = 1'b0; step(45);

    // One clock per bit, no parity.
    b1.d = 7'h01; b1.en = 1'b1; step(1); b1.en = 1'b0; step(12);
    repeat (40) begin
      b1.d = 7'($urandom); b1.en = 1'b1; step(1);
    end
    b1.en = 1'b0; step(12);
    repeat (300) begin
      b1.en = ($urandom % 3 == 0);
      b1.d  = 7'($urandom);
      rstn1 = ($urandom % 40 != 0);
      step(1);
    end
    rstn1 = 1'b1; b1.en = 1'b0; step(15);

    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL frames_missing got=%0d/%0d pending want=0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
